div_8bit: RTL

Sequential signed 8-bit divider, the multi-cycle counterpart to the combinational 8-bit add/subtract datapath. It produces quotient and remainder by restoring shift-and-subtract over operand magnitudes, one quotient bit per clock. It sits beside the add/subtract unit in the arithmetic block, and the sequencer drives it with a start/done handshake. Latency is fixed regardless of operand values.

---
 rtl/div_8bit.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/div_8bit.sv
// Sequential signed 8-bit divider: restoring shift-and-subtract on operand magnitudes,
// one quotient bit per clock, fixed 9-clock latency from accept to done.
module div_8bit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] x,
    input  logic [7:0] y,
    output logic       busy,
    output logic       done,
    output logic [7:0] q,
    output logic [7:0] r,
    output logic       of,
    output logic       dz
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [3:0]  cnt_r;
    logic [7:0]  p_r;       // partial remainder; always < |y| so bit 8 of P is never needed
    logic [7:0]  a_r;
    logic [7:0]  ay_r;
    logic [7:0]  x_r;
    logic [7:0]  y_r;
    logic [8:0]  p_sh_s;
    logic [8:0]  t_s;
    logic [7:0]  fq_s;
    logic [7:0]  fr_s;
    logic        fof_s;
    logic        fdz_s;

    function automatic logic [7:0] abs8(input logic [7:0] v);
        abs8 = v[7] ? (8'd0 - v) : v;
    endfunction

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state selection
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_s = ST_CALC;
                else       state_s = ST_IDLE;
            end
            ST_CALC: begin
                if (cnt_r == 4'd7) state_s = ST_FIX;
                else               state_s = ST_CALC;
            end
            ST_FIX:  state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // One restoring iteration and final result selection
    always_comb begin
        p_sh_s = {p_r, a_r[7]};
        t_s    = p_sh_s - {1'b0, ay_r};
        fq_s   = 8'h00;
        fr_s   = 8'h00;
        fof_s  = 1'b0;
        fdz_s  = 1'b0;
        if (y_r == 8'h00) begin
            fdz_s = 1'b1;
            fr_s  = x_r;
        end else if ((x_r == 8'h80) && (y_r == 8'hFF)) begin
            fof_s = 1'b1;
            fq_s  = 8'h80;
        end else begin
            fq_s = (x_r[7] ^ y_r[7]) ? (8'd0 - a_r) : a_r;
            fr_s = x_r[7] ? (8'd0 - p_r) : p_r;
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= 4'd0;
            p_r   <= 8'h00;
            a_r   <= 8'h00;
            ay_r  <= 8'h00;
            x_r   <= 8'h00;
            y_r   <= 8'h00;
            busy  <= 1'b0;
            done  <= 1'b0;
            q     <= 8'h00;
            r     <= 8'h00;
            of    <= 1'b0;
            dz    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        x_r   <= x;
                        y_r   <= y;
                        a_r   <= abs8(x);
                        ay_r  <= abs8(y);
                        p_r   <= 8'h00;
                        cnt_r <= 4'd0;
                        busy  <= 1'b1;
                    end else begin
                        busy  <= 1'b0;
                    end
                end
                ST_CALC: begin
                    if (!t_s[8]) begin
                        p_r <= t_s[7:0];
                        a_r <= {a_r[6:0], 1'b1};
                    end else begin
                        p_r <= p_sh_s[7:0];
                        a_r <= {a_r[6:0], 1'b0};
                    end
                    cnt_r <= cnt_r + 4'd1;
                end
                ST_FIX: begin
                    q    <= fq_s;
                    r    <= fr_s;
                    of   <= fof_s;
                    dz   <= fdz_s;
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
